// File: rtl/counter_pkg.sv
// Shared constants and types for the synchronous modulo-N up counter.
// Holds default WIDTH/MODULUS, the count_t type and the terminal value.
package counter_pkg;

   localparam int DEF_WIDTH   = 4;
   localparam int DEF_MODULUS = 16;

   typedef logic [DEF_WIDTH-1:0] count_t;

   localparam count_t TC_VALUE = count_t'(DEF_MODULUS - 1);

endpackage

// File: rtl/flipflop_d_pos_clk_pos_rst.sv
// Single D flip-flop: rising-edge clock, asynchronous active-high reset.
// Ports: clk, rst (async, high), d (data in), q (registered out).
module flipflop_d_pos_clk_pos_rst (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= 1'b0;
      else     q <= d;
   end

endmodule

// File: rtl/counter_sync_up_mod.sv
// Fully clocked modulo-MODULUS up counter built from D flip-flop cells.
// Ports: Clk, Clr (async high), En, Load, D -> count, Tc, Co, Wrap.
// Optional parallel load compiled in with COUNTER_SYNC_UP_LOAD_EN.
module counter_sync_up_mod
   import counter_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int MODULUS = DEF_MODULUS
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic             En,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] count,
   output logic             Tc,
   output logic             Co,
   output logic             Wrap
);

   localparam logic [WIDTH-1:0] TC  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] nxt;
   logic             wrap_nxt;

   assign Tc = (count == TC);
   assign Co = Tc & En;

`ifndef COUNTER_SYNC_UP_LOAD_EN
   // Load and D stay on the interface but drive nothing here.
   logic unused_load;
   assign unused_load = ^{Load, D};
`endif

   always_comb begin
      nxt      = count;
      wrap_nxt = 1'b0;
`ifdef COUNTER_SYNC_UP_LOAD_EN
      // Load outranks En; values past the terminal are clamped.
      if (Load) begin
         nxt = (D > TC) ? TC : D;
      end else
`endif
      if (En) begin
         if (Tc) begin
            nxt      = '0;
            wrap_nxt = 1'b1;
         end else begin
            nxt = count + ONE;
         end
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      flipflop_d_pos_clk_pos_rst u_ff (
         .clk (Clk),
         .rst (Clr),
         .d   (nxt[i]),
         .q   (count[i])
      );
   end

   flipflop_d_pos_clk_pos_rst u_wrap (
      .clk (Clk),
      .rst (Clr),
      .d   (wrap_nxt),
      .q   (Wrap)
   );

endmodule
